// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_pkg
// Description : Shared encodings, CC record layout and branch resolve helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cc_pkg;

    localparam logic [2:0] NZP_IDLE = 3'b000;
    localparam logic [2:0] NZP_P    = 3'b001;
    localparam logic [2:0] NZP_Z    = 3'b010;
    localparam logic [2:0] NZP_N    = 3'b100;

    typedef enum logic [1:0] {
        BR_NZP    = 2'b00,
        BR_C      = 2'b01,
        BR_V      = 2'b10,
        BR_ALWAYS = 2'b11
    } br_mode_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic p;
        logic c;
        logic v;
    } cc_rec_t;

    function automatic logic cc_resolve(input cc_rec_t cc, input logic [2:0] mask,
                                        input br_mode_t mode);
        logic taken;
        taken = 1'b0;
        case (mode)
            BR_NZP:  taken = |({cc.n, cc.z, cc.p} & mask);
            BR_C:    taken = cc.c;
            BR_V:    taken = cc.v;
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cc_branch_unit_if
// Description : CC write, branch request and resolution handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface cc_branch_unit_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 1,
    parameter int CNT_W  = 8
);
    logic              we_reg_in;
    logic [SEL_W-1:0]  cc_wsel_in;
    logic [DATA_W-1:0] result_in;
    logic              carry_in;
    logic              ovf_in;
    logic              br_valid_in;
    logic              br_ready_out;
    logic [SEL_W-1:0]  br_sel_in;
    logic [2:0]        br_mask_in;
    logic [1:0]        br_mode_in;
    logic              taken_valid_out;
    logic              taken_ready_in;
    logic              pc_ctl_0_out;
    logic [2:0]        state_out;
    logic [CNT_W-1:0]  taken_cnt_out;

    modport master (
        output we_reg_in, cc_wsel_in, result_in, carry_in, ovf_in,
        output br_valid_in, br_sel_in, br_mask_in, br_mode_in, taken_ready_in,
        input  br_ready_out, taken_valid_out, pc_ctl_0_out, state_out, taken_cnt_out
    );

    modport slave (
        input  we_reg_in, cc_wsel_in, result_in, carry_in, ovf_in,
        input  br_valid_in, br_sel_in, br_mask_in, br_mode_in, taken_ready_in,
        output br_ready_out, taken_valid_out, pc_ctl_0_out, state_out, taken_cnt_out
    );
endinterface
`default_nettype wire

// File: rtl/cc_flag_gen.sv
`default_nettype none
// ============================================================================
// Module      : cc_flag_gen
// Description : Combinational NZP flag generation from an ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_flag_gen #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] result,
    output logic [2:0]        nzp
);
    logic w_n;
    logic w_z;

    assign w_n = result[DATA_W-1];
    assign w_z = (result == '0);
    assign nzp = {w_n, w_z, ~w_n & ~w_z};
endmodule
`default_nettype wire

// File: rtl/cc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : cc_branch_unit
// Description : Condition-code register file with handshaked branch resolve.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_branch_unit
    import cc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CC = 2,
    parameter int SEL_W  = 1,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clka,
    input  logic             reset_in,
    cc_branch_unit_if.slave  bus
);
    localparam logic [SEL_W:0] C_NUM_CC = (SEL_W+1)'(NUM_CC);

    cc_rec_t          r_cc [NUM_CC];
    out_state_t       r_state;
    out_state_t       w_state_nxt;
    logic             r_pc;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0] w_nzp;
    cc_rec_t    w_wr_rec;
    cc_rec_t    w_rd_rec;
    logic       w_wr_valid;
    logic       w_ready;
    logic       w_accept;
    logic       w_taken;

    cc_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
        .result (bus.result_in),
        .nzp    (w_nzp)
    );

    assign w_wr_rec   = {w_nzp, bus.carry_in, bus.ovf_in};
    assign w_wr_valid = bus.we_reg_in && ({1'b0, bus.cc_wsel_in} < C_NUM_CC);

    always_ff @(posedge clka) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_CC; i++) r_cc[i] <= '0;
        end else if (w_wr_valid) begin
            for (int i = 0; i < NUM_CC; i++) begin
                if ({1'b0, bus.cc_wsel_in} == (SEL_W+1)'(i)) r_cc[i] <= w_wr_rec;
            end
        end
    end

    // Out-of-range selects fall through to all-zero flags.
    always_comb begin
        w_rd_rec = '0;
        for (int i = 0; i < NUM_CC; i++) begin
            if ({1'b0, bus.br_sel_in} == (SEL_W+1)'(i)) w_rd_rec = r_cc[i];
        end
        if ((BYPASS != 0) && w_wr_valid && (bus.cc_wsel_in == bus.br_sel_in))
            w_rd_rec = w_wr_rec;
    end

    assign w_taken  = cc_resolve(w_rd_rec, bus.br_mask_in, br_mode_t'(bus.br_mode_in));
    assign w_ready  = (r_state == ST_EMPTY) || bus.taken_ready_in;
    assign w_accept = bus.br_valid_in && w_ready;

    always_ff @(posedge clka) begin
        if (reset_in) r_state <= ST_EMPTY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_accept && bus.taken_ready_in) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset_in) begin
            r_pc  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_pc <= w_taken;
            if (w_taken && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.br_ready_out    = w_ready;
    assign bus.taken_valid_out = (r_state == ST_FULL);
    assign bus.pc_ctl_0_out    = r_pc;
    assign bus.state_out       = {r_cc[0].n, r_cc[0].z, r_cc[0].p};
    assign bus.taken_cnt_out   = r_cnt;
endmodule
`default_nettype wire
